maze_game_ctrl: RTL and testbench

- Frame-paced game sequencer for the VGA maze.
- Turns raw active-low buttons into per-frame step pulses for the square-position datapath.
- Tracks lives; issues respawn on wall collision; schedules the periodic leftward drift.
- Sequences IDLE/PLAY/HIT/WIN. Sits between the button pins, the geometry/collision checker and the square-position registers.

---
 rtl/maze_pkg.sv | 25 ++
 rtl/maze_btn_sync.sv | 26 ++
 rtl/maze_game_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_maze_game_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared definitions for the maze game controller: state encodings,
// spawn point, square size and small width helpers.
package maze_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_HIT  = 2'd2,
    ST_WIN  = 2'd3
  } state_t;

  localparam int SPAWN_X     = 55;
  localparam int SPAWN_Y     = 55;
  localparam int SQUARE_SIZE = 15;

  // Counter width for a counter spanning 0..n-1, never narrower than 1 bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/maze_btn_sync.sv
// Two-flop synchronizer for a bundle of asynchronous button lines.
// Flops reset to RST_VAL so active-low buttons read as released.
module maze_btn_sync #(
  parameter int             W       = 4,
  parameter logic [W-1:0]   RST_VAL = '1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Metastability flop followed by the output flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/maze_game_ctrl.sv
// Frame-paced game sequencer for the VGA maze: turns active-low buttons
// into per-frame step pulses, tracks lives, issues respawns on collision
// and schedules the periodic leftward drift while playing.
// Build option: MAZE_INPUT_SYNC_EN adds a two-flop synchronizer on the
// four buttons; without it buttons are sampled directly on frame_tick.
module maze_game_ctrl
  import maze_pkg::*;
#(
  parameter int LIVES        = 3,
  parameter int HIT_FRAMES   = 30,
  parameter int WIN_FRAMES   = 120,
  parameter int DRIFT_PERIOD = 80_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       moveup,
  input  logic       movedown,
  input  logic       moveright,
  input  logic       start,
  input  logic       collision,
  input  logic       at_goal,
  output logic       step_up,
  output logic       step_down,
  output logic       step_right,
  output logic       drift,
  output logic       respawn,
  output logic [2:0] lives,
  output logic [1:0] state,
  output logic       flash
);

  localparam int FRAME_W = cnt_w(max2(HIT_FRAMES, WIN_FRAMES));
  localparam int DRIFT_W = cnt_w(DRIFT_PERIOD);

  localparam logic [FRAME_W-1:0] HIT_LAST   = FRAME_W'(HIT_FRAMES - 1);
  localparam logic [FRAME_W-1:0] WIN_LAST   = FRAME_W'(WIN_FRAMES - 1);
  localparam logic [DRIFT_W-1:0] DRIFT_LAST = DRIFT_W'(DRIFT_PERIOD - 1);
  localparam logic [2:0]         LIVES_INIT = 3'(LIVES);

  logic up_s, down_s, right_s, start_s;

`ifdef MAZE_INPUT_SYNC_EN
  logic [3:0] btn_s;

  maze_btn_sync #(.W(4), .RST_VAL(4'hF)) u_btn_sync (
    .clk   (clk),
    .reset (reset),
    .d     ({start, moveright, movedown, moveup}),
    .q     (btn_s)
  );

  assign {start_s, right_s, down_s, up_s} = btn_s;
`else
  assign up_s    = moveup;
  assign down_s  = movedown;
  assign right_s = moveright;
  assign start_s = start;
`endif

  state_t             state_q, state_d;
  logic [2:0]         lives_q, lives_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [DRIFT_W-1:0] drift_cnt_q, drift_cnt_d;
  logic up_d, down_d, right_d, drift_d, respawn_d, flash_d;

  // State, counters and all output pulses are registered together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      lives_q     <= '0;
      frame_q     <= '0;
      drift_cnt_q <= '0;
      step_up     <= 1'b0;
      step_down   <= 1'b0;
      step_right  <= 1'b0;
      drift       <= 1'b0;
      respawn     <= 1'b0;
      flash       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      frame_q     <= frame_d;
      drift_cnt_q <= drift_cnt_d;
      step_up     <= up_d;
      step_down   <= down_d;
      step_right  <= right_d;
      drift       <= drift_d;
      respawn     <= respawn_d;
      flash       <= flash_d;
    end
  end

  // Next-state, counter updates and pulse requests; buttons, collision
  // and goal are only looked at on frame_tick cycles.
  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    frame_d     = frame_q;
    drift_cnt_d = drift_cnt_q;
    up_d        = 1'b0;
    down_d      = 1'b0;
    right_d     = 1'b0;
    drift_d     = 1'b0;
    respawn_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (frame_tick && !start_s) begin
          state_d     = ST_PLAY;
          lives_d     = LIVES_INIT;
          respawn_d   = 1'b1;
          drift_cnt_d = '0;
        end
      end

      ST_PLAY: begin
        // Drift runs every clk; a frame_tick step may land on the same cycle.
        if (drift_cnt_q == DRIFT_LAST) begin
          drift_d     = 1'b1;
          drift_cnt_d = '0;
        end else begin
          drift_cnt_d = drift_cnt_q + 1'b1;
        end

        if (frame_tick) begin
          if (collision) begin
            // Respawn wins over drift: the square is being reloaded anyway.
            state_d     = ST_HIT;
            lives_d     = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
            respawn_d   = 1'b1;
            frame_d     = '0;
            drift_d     = 1'b0;
            drift_cnt_d = '0;
          end else if (at_goal) begin
            state_d = ST_WIN;
            frame_d = '0;
          end else if (!up_s) begin
            up_d = 1'b1;
          end else if (!down_s) begin
            down_d = 1'b1;
          end else if (!right_s) begin
            right_d = 1'b1;
          end
        end
      end

      ST_HIT: begin
        if (frame_tick) begin
          if (frame_q == HIT_LAST) begin
            frame_d = '0;
            if (lives_q == 3'd0) begin
              state_d = ST_IDLE;
            end else begin
              state_d     = ST_PLAY;
              drift_cnt_d = '0;
            end
          end else begin
            frame_d = frame_q + 1'b1;
          end
        end
      end

      ST_WIN: begin
        if (frame_tick) begin
          if (frame_q == WIN_LAST) begin
            frame_d = '0;
            state_d = ST_IDLE;
          end else begin
            frame_d = frame_q + 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    flash_d = (state_d == ST_HIT);
  end

  assign lives = lives_q;
  assign state = state_q;

endmodule

// File: tb/tb_maze_game_ctrl.sv
// Scoreboard bench for maze_game_ctrl. Instance A uses the default timing
// with a drift period too long to fire; instance B uses DRIFT_PERIOD=10.
module tb_maze_game_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  function void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function void unexpected(string name, logic [31:0] act);
    n_chk++;
    n_fail++;
    $display("FAIL %s: unexpected output %0h with nothing expected", name, act);
  endfunction

  logic reset;

  // ---------------- instance A ----------------
  logic ft_a, up_a, dn_a, rt_a, st_a, col_a, goal_a;
  logic su_a, sd_a, sr_a, dr_a, rs_a, fl_a;
  logic [2:0] lv_a;
  logic [1:0] state_a;

  maze_game_ctrl #(.LIVES(3), .HIT_FRAMES(30), .WIN_FRAMES(120), .DRIFT_PERIOD(1_000_000)) dut_a (
    .clk(clk), .reset(reset), .frame_tick(ft_a),
    .moveup(up_a), .movedown(dn_a), .moveright(rt_a), .start(st_a),
    .collision(col_a), .at_goal(goal_a),
    .step_up(su_a), .step_down(sd_a), .step_right(sr_a), .drift(dr_a),
    .respawn(rs_a), .lives(lv_a), .state(state_a), .flash(fl_a)
  );

  // ---------------- instance B ----------------
  logic ft_b, up_b, dn_b, rt_b, st_b, col_b, goal_b;
  logic su_b, sd_b, sr_b, dr_b, rs_b, fl_b;
  logic [2:0] lv_b;
  logic [1:0] state_b;

  maze_game_ctrl #(.LIVES(3), .HIT_FRAMES(30), .WIN_FRAMES(120), .DRIFT_PERIOD(10)) dut_b (
    .clk(clk), .reset(reset), .frame_tick(ft_b),
    .moveup(up_b), .movedown(dn_b), .moveright(rt_b), .start(st_b),
    .collision(col_b), .at_goal(goal_b),
    .step_up(su_b), .step_down(sd_b), .step_right(sr_b), .drift(dr_b),
    .respawn(rs_b), .lives(lv_b), .state(state_b), .flash(fl_b)
  );

  // Pulse vector order: {step_up, step_down, step_right, drift, respawn}
  typedef struct {
    string      name;
    logic [4:0] pl;
    logic [1:0] st;
    logic [2:0] lv;
    logic       fl;
  } exp_a_t;

  typedef struct {
    string      name;
    int         cyc;
    logic [4:0] pl;
    logic [1:0] st;
  } exp_b_t;

  exp_a_t qa[$];
  exp_b_t qb[$];

  task automatic expa(string n, logic [4:0] pl, logic [1:0] st, logic [2:0] lv, logic fl);
    exp_a_t e;
    e.name = n; e.pl = pl; e.st = st; e.lv = lv; e.fl = fl;
    qa.push_back(e);
  endtask

  task automatic expb(string n, int c, logic [4:0] pl, logic [1:0] st);
    exp_b_t e;
    e.name = n; e.cyc = c; e.pl = pl; e.st = st;
    qb.push_back(e);
  endtask

  // Monitor A: any pulse or state change is an output event.
  logic [1:0] prev_st_a = 2'd0;
  always @(negedge clk) begin
    logic [4:0] pl;
    exp_a_t     e;
    pl = {su_a, sd_a, sr_a, dr_a, rs_a};
    if (pl != 5'd0 || state_a != prev_st_a) begin
      if (qa.size() == 0) begin
        unexpected("mon_a", 32'({pl, state_a, lv_a, fl_a}));
      end else begin
        e = qa.pop_front();
        chk(e.name, 32'({pl, state_a, lv_a, fl_a}), 32'({e.pl, e.st, e.lv, e.fl}));
      end
    end
    prev_st_a = state_a;
  end

  // Monitor B: pulses are checked for both value and cycle of arrival.
  always @(negedge clk) begin
    logic [4:0] pl;
    exp_b_t     e;
    pl = {su_b, sd_b, sr_b, dr_b, rs_b};
    if (pl != 5'd0) begin
      if (qb.size() == 0) begin
        unexpected("mon_b", 32'({pl, state_b}));
      end else begin
        e = qb.pop_front();
        chk({e.name, "_cyc"}, 32'(cyc), 32'(e.cyc));
        chk(e.name, 32'({pl, state_b}), 32'({e.pl, e.st}));
      end
    end
  end

  // One frame on instance A; inputs settle 3 clks before the tick.
  task automatic tick_a();
    repeat (3) @(posedge clk);
    #1 ft_a = 1'b1;
    @(posedge clk);
    #1 ft_a = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic wait_to(int n);
    for (int i = 0; i < 2000 && cyc < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  int t0;

  initial begin
    reset = 1'b0;
    {ft_a, col_a, goal_a} = 3'b000;
    {up_a, dn_a, rt_a, st_a} = 4'hF;
    {ft_b, col_b, goal_b} = 3'b000;
    {up_b, dn_b, rt_b, st_b} = 4'hF;

    #22;
    chk("rst_state", 32'(state_a), 32'd0);
    chk("rst_lives", 32'(lv_a), 32'd0);
    chk("rst_outs", 32'({su_a, sd_a, sr_a, dr_a, rs_a, fl_a}), 32'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // IDLE ignores movement and ticks without start.
    up_a = 1'b0; tick_a(); up_a = 1'b1;

    // Start the game.
    st_a = 1'b0;
    expa("start", 5'b00001, 2'd1, 3'd3, 1'b0);
    tick_a();

    // up+right held 5 frames (start still held, ignored in PLAY).
    up_a = 1'b0; rt_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      expa("up_pri", 5'b10000, 2'd1, 3'd3, 1'b0);
      tick_a();
    end
    st_a = 1'b1;
    up_a = 1'b1;
    expa("right_only", 5'b00100, 2'd1, 3'd3, 1'b0);
    tick_a();
    dn_a = 1'b0;
    expa("down_pri", 5'b01000, 2'd1, 3'd3, 1'b0);
    tick_a();
    dn_a = 1'b1; rt_a = 1'b1;
    tick_a();  // no button: no step

    // Collision and goal together: collision wins.
    col_a = 1'b1; goal_a = 1'b1;
    expa("hit", 5'b00001, 2'd2, 3'd2, 1'b1);
    tick_a();
    col_a = 1'b0; goal_a = 1'b0; up_a = 1'b0;
    for (int i = 0; i < 29; i++) tick_a();
    chk("hit_flash", 32'(fl_a), 32'd1);
    expa("hit_end", 5'b00000, 2'd1, 3'd2, 1'b0);
    tick_a();
    up_a = 1'b1;

    // Reset mid-PLAY with a step in flight.
    repeat (3) @(posedge clk);
    #1 up_a = 1'b0; ft_a = 1'b1; reset = 1'b0;
    expa("rst_mid", 5'b00000, 2'd0, 3'd0, 1'b0);
    #1;
    chk("rst_mid_state", 32'(state_a), 32'd0);
    chk("rst_mid_lives", 32'(lv_a), 32'd0);
    @(posedge clk); #1;
    chk("rst_mid_pulses", 32'({su_a, sd_a, sr_a, dr_a, rs_a, fl_a}), 32'd0);
    ft_a = 1'b0; up_a = 1'b1;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // Three collisions to game over.
    st_a = 1'b0;
    expa("start2", 5'b00001, 2'd1, 3'd3, 1'b0);
    tick_a();
    st_a = 1'b1;
    for (int k = 0; k < 3; k++) begin
      col_a = 1'b1;
      expa("col", 5'b00001, 2'd2, 3'(2 - k), 1'b1);
      tick_a();
      col_a = 1'b0;
      for (int i = 0; i < 29; i++) tick_a();
      if (k < 2) expa("col_end", 5'b00000, 2'd1, 3'(2 - k), 1'b0);
      else       expa("game_over", 5'b00000, 2'd0, 3'd0, 1'b0);
      tick_a();
    end

    // Win path: lives retained on return to IDLE.
    st_a = 1'b0;
    expa("start3", 5'b00001, 2'd1, 3'd3, 1'b0);
    tick_a();
    goal_a = 1'b1;
    expa("win", 5'b00000, 2'd3, 3'd3, 1'b0);
    tick_a();
    goal_a = 1'b0;
    for (int i = 0; i < 119; i++) begin
      if (i == 10) st_a = 1'b1;
      tick_a();
    end
    expa("win_end", 5'b00000, 2'd0, 3'd3, 1'b0);
    tick_a();
    tick_a();

    // Instance B: drift cadence, drift+step coincidence, drift vs collision.
    st_b = 1'b0;
    repeat (3) @(posedge clk);
    #1 t0 = cyc + 1;
    ft_b = 1'b1;
    expb("b_start", t0, 5'b00001, 2'd1);
    expb("b_drift1", t0 + 10, 5'b00010, 2'd1);
    @(posedge clk); #1;
    ft_b = 1'b0; st_b = 1'b1;
    wait_to(t0 + 16);
    dn_b = 1'b0;
    wait_to(t0 + 19);
    ft_b = 1'b1;
    expb("b_drift_step", t0 + 20, 5'b01010, 2'd1);
    @(posedge clk); #1;
    ft_b = 1'b0; dn_b = 1'b1;
    wait_to(t0 + 29);
    ft_b = 1'b1; col_b = 1'b1;
    expb("b_col", t0 + 30, 5'b00001, 2'd2);
    @(posedge clk); #1;
    ft_b = 1'b0; col_b = 1'b0;
    wait_to(t0 + 60);
    chk("b_state_hit", 32'(state_b), 32'd2);

    repeat (10) @(posedge clk);
    chk("qa_empty", 32'(qa.size()), 32'd0);
    chk("qb_empty", 32'(qb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
